// File: rtl/ifid_buffer.sv
// Fetch/decode buffer: a small circular FIFO of {word address, instruction} with a
// valid/ready head, pre-split instruction fields and branch/jump classification.
module ifid_buffer #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 30,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_instr,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_funct,
    output logic [15:0]       out_imm16,
    output logic [31:0]       out_imm_sext,
    output logic [25:0]       out_target,
    output logic              out_is_branch,
    output logic              out_is_jump,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [31:0]       instr_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              push, pop;

    // Handshake flags come only from registered count, so in_ready never sees out_ready.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: storage is reset too, so the gated head decode starts from known zeros.
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register update using pre-edge values.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                addr_q[wr_ptr_q]  <= in_addr;
                instr_q[wr_ptr_q] <= in_instr;
            end
        end
    end

    // Head decode: zero everything while empty so decode never sees stale storage.
    logic [31:0] head_instr;
    assign head_instr = out_valid ? instr_q[rd_ptr_q] : 32'h0;
    assign out_addr   = out_valid ? addr_q[rd_ptr_q]  : '0;
    assign out_instr  = head_instr;

    assign out_opcode   = head_instr[31:26];
    assign out_rs       = head_instr[25:21];
    assign out_rt       = head_instr[20:16];
    assign out_rd       = head_instr[15:11];
    assign out_shamt    = head_instr[10:6];
    assign out_funct    = head_instr[5:0];
    assign out_imm16    = head_instr[15:0];
    assign out_imm_sext = {{16{head_instr[15]}}, head_instr[15:0]};
    assign out_target   = head_instr[25:0];

    assign out_is_branch = out_valid &
                           ((out_opcode == OP_BEQ) || (out_opcode == OP_BNE));
    assign out_is_jump   = out_valid &
                           ((out_opcode == OP_J) || (out_opcode == OP_JAL) ||
                            ((out_opcode == OP_SPECIAL) && (out_funct == FN_JR)));

endmodule
